// File: rtl/decoder_3to8.sv
`default_nettype none
// ============================================================================
// Module   : decoder_3to8
// Purpose  : Registered 3-to-8 one-hot decoder with enable and selectable
//            output polarity. Define DECODER38_COMB_BYPASS_EN for a purely
//            combinational, zero-latency build.
// Revision : 1.0 - initial release
// ============================================================================
module decoder_3to8 #(
    parameter bit OUT_ACTIVE_LOW = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic a,
    input  logic b,
    input  logic c,
    output logic y0,
    output logic y1,
    output logic y2,
    output logic y3,
    output logic y4,
    output logic y5,
    output logic y6,
    output logic y7
);

    logic [2:0] w_sel;
    logic [7:0] w_hot;
    logic [7:0] w_act;
    logic [7:0] w_y;

    assign w_sel = {a, b, c};

    always_comb begin
        w_hot = '0;
        if (en) begin
            w_hot[w_sel] = 1'b1;
        end
    end

`ifdef DECODER38_COMB_BYPASS_EN
    // Port kept only so both builds share one interface.
    logic w_unused_clk;
    assign w_unused_clk = clk;

    assign w_act = rst ? '0 : w_hot;
`else
    logic [7:0] r_hot;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hot <= '0;
        end else begin
            r_hot <= w_hot;
        end
    end

    assign w_act = r_hot;
`endif

    generate
        if (OUT_ACTIVE_LOW) begin : g_active_low
            assign w_y = ~w_act;
        end else begin : g_active_high
            assign w_y = w_act;
        end
    endgenerate

    assign {y7, y6, y5, y4, y3, y2, y1, y0} = w_y;

endmodule
`default_nettype wire

// File: tb/tb_decoder_3to8.sv
`default_nettype none
// ============================================================================
// Module   : tb_decoder_3to8
// Purpose  : Self-checking bench for decoder_3to8, both output polarities.
// Revision : 1.0 - initial release
// ============================================================================
module tb_decoder_3to8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en  = 1'b0;
    logic a   = 1'b0;
    logic b   = 1'b0;
    logic c   = 1'b0;

    logic h0, h1, h2, h3, h4, h5, h6, h7;
    logic l0, l1, l2, l3, l4, l5, l6, l7;
    logic [7:0] y_hi;
    logic [7:0] y_lo;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    decoder_3to8 #(.OUT_ACTIVE_LOW(1'b0)) dut_hi (
        .clk(clk), .rst(rst), .en(en), .a(a), .b(b), .c(c),
        .y0(h0), .y1(h1), .y2(h2), .y3(h3), .y4(h4), .y5(h5), .y6(h6), .y7(h7)
    );

    decoder_3to8 #(.OUT_ACTIVE_LOW(1'b1)) dut_lo (
        .clk(clk), .rst(rst), .en(en), .a(a), .b(b), .c(c),
        .y0(l0), .y1(l1), .y2(l2), .y3(l3), .y4(l4), .y5(l5), .y6(l6), .y7(l7)
    );

    assign y_hi = {h7, h6, h5, h4, h3, h2, h1, h0};
    assign y_lo = {l7, l6, l5, l4, l3, l2, l1, l0};

    typedef struct {
        logic       r;
        logic       e;
        logic [2:0] s;
        logic [7:0] y;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Drive one set of inputs and let them take effect: one clock edge in the
    // registered build, a settle delay in the combinational build.
    task automatic apply(input logic r, input logic e, input logic [2:0] s);
        rst = r;
        en  = e;
        {a, b, c} = s;
`ifdef DECODER38_COMB_BYPASS_EN
        #1;
`else
        @(posedge clk);
        #1;
`endif
    endtask

    // Reference: active output index is the select value read as a number.
    function automatic logic [7:0] model(input logic r, input logic e, input logic [2:0] s);
        if (r || !e) return 8'd0;
        return 8'(2 ** int'(s));
    endfunction

    initial begin
        logic [7:0] exp;
        logic [2:0] s;
        logic       r;
        logic       e;
        logic       f_act;
        logic       f_exp;

        vecs[0]  = '{1'b1, 1'b1, 3'd5, 8'b0000_0000};
        vecs[1]  = '{1'b0, 1'b1, 3'd5, 8'b0010_0000};
        vecs[2]  = '{1'b0, 1'b1, 3'd0, 8'b0000_0001};
        vecs[3]  = '{1'b0, 1'b1, 3'd1, 8'b0000_0010};
        vecs[4]  = '{1'b0, 1'b1, 3'd2, 8'b0000_0100};
        vecs[5]  = '{1'b0, 1'b1, 3'd3, 8'b0000_1000};
        vecs[6]  = '{1'b0, 1'b1, 3'd4, 8'b0001_0000};
        vecs[7]  = '{1'b0, 1'b1, 3'd5, 8'b0010_0000};
        vecs[8]  = '{1'b0, 1'b1, 3'd6, 8'b0100_0000};
        vecs[9]  = '{1'b0, 1'b1, 3'd7, 8'b1000_0000};
        vecs[10] = '{1'b0, 1'b1, 3'd3, 8'b0000_1000};
        vecs[11] = '{1'b0, 1'b0, 3'd3, 8'b0000_0000};
        vecs[12] = '{1'b0, 1'b1, 3'd3, 8'b0000_1000};
        vecs[13] = '{1'b1, 1'b1, 3'd7, 8'b0000_0000};
        vecs[14] = '{1'b0, 1'b1, 3'd6, 8'b0100_0000};

        for (int i = 0; i < 15; i++) begin
            apply(vecs[i].r, vecs[i].e, vecs[i].s);
            check($sformatf("vec%0d_hi", i), y_hi, vecs[i].y);
            check($sformatf("vec%0d_lo", i), y_lo, ~vecs[i].y);
        end

        // Minterm composition f = a~b + ab~c + ~bc, observed as y1|y4|y5|y6.
        for (int i = 0; i < 8; i++) begin
            s = 3'(i);
            apply(1'b0, 1'b1, s);
            f_act = h1 | h4 | h5 | h6;
            f_exp = (s[2] & ~s[1]) | (s[2] & s[1] & ~s[0]) | (~s[1] & s[0]);
            check($sformatf("minterm_%0d", i), {7'd0, f_act}, {7'd0, f_exp});
        end

`ifdef DECODER38_COMB_BYPASS_EN
        apply(1'b0, 1'b1, 3'd0);
        #3;
        {a, b, c} = 3'b010;
        #1;
        check("bypass_sel_hi", y_hi, 8'b0000_0100);
        check("bypass_sel_lo", y_lo, 8'b1111_1011);
        en = 1'b0;
        #1;
        check("bypass_en_off", y_hi, 8'b0000_0000);
        rst = 1'b1;
        en  = 1'b1;
        #1;
        check("bypass_rst", y_hi, 8'b0000_0000);
`else
        // Select changes between edges must not reach the outputs.
        apply(1'b0, 1'b1, 3'd3);
        {a, b, c} = 3'b110;
        #2;
        check("hold_between_edges", y_hi, 8'b0000_1000);
        @(posedge clk);
        #1;
        check("after_next_edge", y_hi, 8'b0100_0000);
`endif

        for (int i = 0; i < 200; i++) begin
            r = ($urandom_range(0, 7) == 0);
            e = ($urandom_range(0, 3) != 0);
            s = 3'($urandom_range(0, 7));
            apply(r, e, s);
            exp = model(r, e, s);
            check($sformatf("rand%0d_hi", i), y_hi, exp);
            check($sformatf("rand%0d_lo", i), y_lo, ~exp);
            check($sformatf("rand%0d_ones", i), 8'($countones(y_hi)), 8'((!r && e) ? 1 : 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/decoder_3to8.md
Name: decoder_3to8

Overview:
- Registered 3-to-8 line decoder with enable. Select inputs a (MSB), b, c (LSB) drive exactly one of eight one-hot outputs y0..y7.
- Used as a minterm generator: downstream logic ORs selected outputs to build arbitrary 3-input sum-of-products functions.
- Example: a·~b + a·b·~c + ~b·c = y1|y4|y5|y6.

Parameters:
- OUT_ACTIVE_LOW, default 0. When 0, the selected output is 1 and all others are 0. When 1, every output is inverted: the selected output is 0, others are 1, and the idle/reset value is all 1s.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous reset, active-high.
- en   input  1  decode enable, active-high.
- a    input  1  select bit 2 (MSB).
- b    input  1  select bit 1.
- c    input  1  select bit 0 (LSB).
- y0..y7  output  1 each  decoded outputs, indexed by {a,b,c}. y0 corresponds to 000 and y7 to 111.
- Positional order after clk, rst, en is a, b, c, y0, y1, y2, y3, y4, y5, y6, y7.

Behaviour:
- Index: sel = {a,b,c}, a 3-bit unsigned value.
- Default build: outputs are registered, with one clock cycle of latency.
- On each rising clk edge with rst=1:
  - All eight outputs become inactive (0 when OUT_ACTIVE_LOW=0).
  - rst has priority over en and the selects.
- On each rising clk edge with rst=0 and en=1:
  - y[sel] becomes active.
  - All other outputs become inactive.
- On each rising clk edge with rst=0 and en=0: all outputs become inactive. Outputs do not hold their previous value.
- Invariant with OUT_ACTIVE_LOW=0: after any edge, at most one output is high. Exactly one is high iff the previous edge sampled rst=0 and en=1.
- Before the first clock edge, output values are undefined. The bench applies rst for at least one edge.
- Reset mid-operation: the edge that samples rst=1 clears the outputs. The first edge with rst=0 and en=1 produces a decode.
- Select changes between edges have no effect on outputs until the next edge.
- X/Z on a, b, c while en=1 gives undefined outputs. No checking is performed.
- Truth table (OUT_ACTIVE_LOW=0, en=1):
  - 000 → y0; 001 → y1; 010 → y2; 011 → y3
  - 100 → y4; 101 → y5; 110 → y6; 111 → y7

Optional Feature:
- Macro DECODER38_COMB_BYPASS_EN.
- Defined: output registers are removed and the decode is purely combinational, with zero latency.
  - y[sel] is active whenever en=1 and rst=0.
  - All outputs are inactive while rst=1 or en=0.
  - clk is unused; the port is kept for interface compatibility.
- Not defined: registered behaviour as described above, one-cycle latency.
- OUT_ACTIVE_LOW applies identically in both builds.

Test Plan:
1. Reset: set rst=1, en=1, abc=101 and apply one edge → y0..y7 = 0. Release rst; the next edge gives y5=1 and all other outputs 0.
2. Exhaustive sweep: en=1, rst=0, step abc 000→111, one value per cycle → one cycle after each step, only y[abc] is 1. Check the one-hot property every cycle.
3. Enable gating: abc=011, en=1 for one edge gives y3=1. Then drop en=0 for one edge → all outputs 0. Set en=1 again → y3=1 after the next edge.
4. Minterm composition: sweep abc 000→111 and compute f = y1|y4|y5|y6 one cycle later → f = 0,1,0,0,1,1,1,0 for abc = 000..111.
5. Polarity and priority:
   - With OUT_ACTIVE_LOW=1, rst=1 → all outputs 1. Then en=1, abc=110 → y6=0 and all others 1.
   - Asserting rst together with en=1 and abc=111 → all outputs inactive at that edge.
6. Bypass build (DECODER38_COMB_BYPASS_EN defined): en=1, rst=0, change abc to 010 mid-cycle → y2=1 immediately, with no clock edge needed. Setting en=0 → all outputs 0 immediately.
